lcd_ctrl_param: RTL and testbench

Parametrised image-processing LCD controller. It loads a W×H pixel image from an asynchronous-read IROM into an internal buffer. It then executes single-cycle window commands on a 2×2 window (move, max/min/avg, rotate, mirror) and writes the buffer back to IRAM. This generation adds configurable image size, pixel width and edge mode (saturate or wrap), plus a RELOAD command. It also supports repeated write-back sessions without reset, with `done` signalled as a pulse.

---
 rtl/lcd_ctrl_pkg.sv | 25 ++
 rtl/lcd_win_alu.sv | 55 +++++
 rtl/lcd_ctrl_param.sv | 169 ++++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the parametrised LCD image controller:
// command codes and controller state encoding.
package lcd_ctrl_pkg;

  localparam logic [3:0] CMD_WRITE  = 4'd0;
  localparam logic [3:0] CMD_UP     = 4'd1;
  localparam logic [3:0] CMD_DOWN   = 4'd2;
  localparam logic [3:0] CMD_LEFT   = 4'd3;
  localparam logic [3:0] CMD_RIGHT  = 4'd4;
  localparam logic [3:0] CMD_MAX    = 4'd5;
  localparam logic [3:0] CMD_MIN    = 4'd6;
  localparam logic [3:0] CMD_AVG    = 4'd7;
  localparam logic [3:0] CMD_CCW    = 4'd8;
  localparam logic [3:0] CMD_CW     = 4'd9;
  localparam logic [3:0] CMD_MX     = 4'd10;
  localparam logic [3:0] CMD_MY     = 4'd11;
  localparam logic [3:0] CMD_RELOAD = 4'd12;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_IDLE,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: max/min/avg fill and
// the four pixel permutations; we flags a buffer update.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    cmd,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] na,
  output logic [DW-1:0] nb,
  output logic [DW-1:0] nc,
  output logic [DW-1:0] nd,
  output logic          we
);

  logic [DW-1:0] mx_ab, mx_cd, mx;
  logic [DW-1:0] mn_ab, mn_cd, mn;
  logic [DW+1:0] sum;
  logic [DW-1:0] avg;

  assign mx_ab = (a > b) ? a : b;
  assign mx_cd = (c > d) ? c : d;
  assign mx    = (mx_ab > mx_cd) ? mx_ab : mx_cd;
  assign mn_ab = (a < b) ? a : b;
  assign mn_cd = (c < d) ? c : d;
  assign mn    = (mn_ab < mn_cd) ? mn_ab : mn_cd;

  // two guard bits keep the four-way sum exact
  assign sum = {2'b00, a} + {2'b00, b}
             + {2'b00, c} + {2'b00, d};
  assign avg = sum[DW+1:2];

  always_comb begin
    na = a;
    nb = b;
    nc = c;
    nd = d;
    we = 1'b1;
    case (cmd)
      CMD_MAX: {na, nb, nc, nd} = {4{mx}};
      CMD_MIN: {na, nb, nc, nd} = {4{mn}};
      CMD_AVG: {na, nb, nc, nd} = {4{avg}};
      CMD_CCW: {na, nb, nc, nd} = {b, d, a, c};
      CMD_CW:  {na, nb, nc, nd} = {c, a, d, b};
      CMD_MX:  {na, nb, nc, nd} = {c, d, a, b};
      CMD_MY:  {na, nb, nc, nd} = {b, a, d, c};
      default: we = 1'b0;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads a WxH image from IROM, applies
// 2x2 window commands, and writes the buffer back to IRAM.
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int DW   = 8,
  parameter int WL2  = 3,
  parameter int HL2  = 3,
  parameter int WRAP = 0,
  localparam int AW  = WL2 + HL2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  output logic          IRAM_valid,
  output logic [DW-1:0] IRAM_D,
  output logic [AW-1:0] IRAM_A,
  output logic          busy,
  output logic          done
);

  localparam int N = 1 << AW;
  localparam logic [AW-1:0]  LAST  = AW'(N - 1);
  localparam logic [HL2-1:0] RMAX  = HL2'((1 << HL2) - 2);
  localparam logic [WL2-1:0] CMAX  = WL2'((1 << WL2) - 2);
  localparam logic [HL2-1:0] RINIT = HL2'((1 << (HL2 - 1)) - 1);
  localparam logic [WL2-1:0] CINIT = WL2'((1 << (WL2 - 1)) - 1);
  localparam bit WRAP_EN = (WRAP != 0);

  state_t         state, state_n;
  logic [AW-1:0]  cnt, cnt_n;
  logic           busy_n, rd_n, valid_n, done_n;
  logic [HL2-1:0] row, row_n;
  logic [WL2-1:0] col, col_n;
  logic [DW-1:0]  mem [N];

  logic [AW-1:0] pa, pb, pc, pd;
  logic [DW-1:0] na, nb, nc, nd;
  logic          alu_we, win_we, load_we;

  assign pa = {row, col};
  assign pb = {row, col + WL2'(1)};
  assign pc = {row + HL2'(1), col};
  assign pd = {row + HL2'(1), col + WL2'(1)};

  lcd_win_alu #(.DW(DW)) u_alu (
    .cmd (cmd),
    .a   (mem[pa]),
    .b   (mem[pb]),
    .c   (mem[pc]),
    .d   (mem[pd]),
    .na  (na),
    .nb  (nb),
    .nc  (nc),
    .nd  (nd),
    .we  (alu_we)
  );

  assign load_we = (state == ST_LOAD);
  assign win_we  = (state == ST_IDLE) && cmd_valid && alu_we;

  assign IROM_A = cnt;
  assign IRAM_A = cnt;
  assign IRAM_D = mem[cnt];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = busy;
    rd_n    = IROM_rd;
    valid_n = IRAM_valid;
    done_n  = 1'b0;
    row_n   = row;
    col_n   = col;
    case (state)
      ST_LOAD: begin
        cnt_n = cnt + AW'(1);
        if (cnt == LAST) begin
          cnt_n   = '0;
          rd_n    = 1'b0;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_WRITE: begin
              valid_n = 1'b1;
              busy_n  = 1'b1;
              state_n = ST_WRITE;
            end
            CMD_UP:
              row_n = (row != '0) ? row - HL2'(1)
                    : (WRAP_EN ? RMAX : row);
            CMD_DOWN:
              row_n = (row != RMAX) ? row + HL2'(1)
                    : (WRAP_EN ? '0 : row);
            CMD_LEFT:
              col_n = (col != '0) ? col - WL2'(1)
                    : (WRAP_EN ? CMAX : col);
            CMD_RIGHT:
              col_n = (col != CMAX) ? col + WL2'(1)
                    : (WRAP_EN ? '0 : col);
            CMD_RELOAD: begin
              cnt_n   = '0;
              busy_n  = 1'b1;
              rd_n    = 1'b1;
              state_n = ST_LOAD;
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        cnt_n = cnt + AW'(1);
        if (cnt == LAST) begin
          cnt_n   = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      busy       <= 1'b1;
      IROM_rd    <= 1'b1;
      IRAM_valid <= 1'b0;
      done       <= 1'b0;
      row        <= RINIT;
      col        <= CINIT;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      busy       <= busy_n;
      IROM_rd    <= rd_n;
      IRAM_valid <= valid_n;
      done       <= done_n;
      row        <= row_n;
      col        <= col_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      if (load_we) mem[cnt] <= IROM_Q;
      if (win_we) begin
        mem[pa] <= na;
        mem[pb] <= nb;
        mem[pc] <= nc;
        mem[pd] <= nd;
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: an 8x8 saturating instance and a
// 16x8, 12-bit wrapping instance against an image-level model.
module tb_lcd_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0, cv0, rd0, wv0, busy0, done0;
  logic [3:0] cmd0;
  logic [7:0] q0, wd0;
  logic [5:0] ra0, wa0;

  logic        reset1, cv1, rd1, wv1, busy1, done1;
  logic [3:0]  cmd1;
  logic [11:0] q1, wd1;
  logic [6:0]  ra1, wa1;

  int rom  [2][128];
  int mimg [2][128];
  int cap  [2][128];
  int mrow [2];
  int mcol [2];
  int mw   [2] = '{8, 16};
  int mh   [2] = '{8, 8};
  int mwrap[2] = '{0, 1};
  int total = 0;
  int bad = 0;

  assign q0 = 8'(rom[0][ra0]);
  assign q1 = 12'(rom[1][ra1]);

  lcd_ctrl_param #(.DW(8), .WL2(3), .HL2(3), .WRAP(0)) u_dut0 (
    .clk(clk), .reset(reset0), .cmd(cmd0), .cmd_valid(cv0),
    .IROM_Q(q0), .IROM_rd(rd0), .IROM_A(ra0),
    .IRAM_valid(wv0), .IRAM_D(wd0), .IRAM_A(wa0),
    .busy(busy0), .done(done0)
  );

  lcd_ctrl_param #(.DW(12), .WL2(4), .HL2(3), .WRAP(1)) u_dut1 (
    .clk(clk), .reset(reset1), .cmd(cmd1), .cmd_valid(cv1),
    .IROM_Q(q1), .IROM_rd(rd1), .IROM_A(ra1),
    .IRAM_valid(wv1), .IRAM_D(wd1), .IRAM_A(wa1),
    .busy(busy1), .done(done1)
  );

  function automatic logic o_busy(bit u);
    return u ? busy1 : busy0;
  endfunction
  function automatic logic o_done(bit u);
    return u ? done1 : done0;
  endfunction
  function automatic logic o_rd(bit u);
    return u ? rd1 : rd0;
  endfunction
  function automatic logic o_wv(bit u);
    return u ? wv1 : wv0;
  endfunction
  function automatic int o_ra(bit u);
    return u ? int'(ra1) : int'(ra0);
  endfunction
  function automatic int o_wa(bit u);
    return u ? int'(wa1) : int'(wa0);
  endfunction
  function automatic int o_wd(bit u);
    return u ? int'(wd1) : int'(wd0);
  endfunction

  task automatic drive(bit u, int c, bit v);
    if (u) begin cmd1 = 4'(c); cv1 = v; end
    else begin cmd0 = 4'(c); cv0 = v; end
  endtask

  task automatic model_reset(bit u);
    for (int i = 0; i < 128; i++) mimg[u][i] = 0;
    mrow[u] = mh[u] / 2 - 1;
    mcol[u] = mw[u] / 2 - 1;
  endtask

  // image-level meaning of each command
  task automatic model_cmd(bit u, int c);
    int w, h, ia, ib, ic, id, m;
    int v[4];
    int nv[4];
    w = mw[u]; h = mh[u];
    ia = mrow[u] * w + mcol[u];
    ib = ia + 1; ic = ia + w; id = ic + 1;
    v[0] = mimg[u][ia]; v[1] = mimg[u][ib];
    v[2] = mimg[u][ic]; v[3] = mimg[u][id];
    nv = v;
    case (c)
      1: if (mrow[u] > 0) mrow[u]--;
         else if (mwrap[u] != 0) mrow[u] = h - 2;
      2: if (mrow[u] < h - 2) mrow[u]++;
         else if (mwrap[u] != 0) mrow[u] = 0;
      3: if (mcol[u] > 0) mcol[u]--;
         else if (mwrap[u] != 0) mcol[u] = w - 2;
      4: if (mcol[u] < w - 2) mcol[u]++;
         else if (mwrap[u] != 0) mcol[u] = 0;
      5: begin
        m = v[0];
        for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
        nv = '{m, m, m, m};
      end
      6: begin
        m = v[0];
        for (int k = 1; k < 4; k++) if (v[k] < m) m = v[k];
        nv = '{m, m, m, m};
      end
      7: begin
        m = (v[0] + v[1] + v[2] + v[3]) / 4;
        nv = '{m, m, m, m};
      end
      8:  nv = '{v[1], v[3], v[0], v[2]};
      9:  nv = '{v[2], v[0], v[3], v[1]};
      10: nv = '{v[2], v[3], v[0], v[1]};
      11: nv = '{v[1], v[0], v[3], v[2]};
      default: ;
    endcase
    mimg[u][ia] = nv[0]; mimg[u][ib] = nv[1];
    mimg[u][ic] = nv[2]; mimg[u][id] = nv[3];
  endtask

  task automatic issue(bit u, int c);
    drive(u, c, 1'b1);
    model_cmd(u, c);
    @(negedge clk);
    drive(u, 0, 1'b0);
  endtask

  task automatic run_cmds(bit u, int n);
    int c;
    for (int i = 0; i < n; i++) begin
      c = int'($urandom_range(1, 14));
      if (c == 12) c = 13;
      if ($urandom_range(0, 4) == 0) drive(u, c, 1'b0);
      else begin
        drive(u, c, 1'b1);
        model_cmd(u, c);
      end
      @(negedge clk);
    end
    drive(u, 0, 1'b0);
  endtask

  task automatic wait_load(bit u, bit noise, bit clear);
    int n, k, errs, fk, fa;
    n = mw[u] * mh[u];
    k = 0; errs = 0; fk = -1; fa = -1;
    while (o_busy(u) === 1'b1 && k < n + 8) begin
      if (o_ra(u) != k || o_rd(u) !== 1'b1 ||
          o_wv(u) !== 1'b0 || o_done(u) !== 1'b0 ||
          (clear && o_wd(u) != 0)) begin
        if (errs == 0) begin fk = k; fa = o_ra(u); end
        errs++;
      end
      if (noise) drive(u, int'($urandom_range(0, 15)), 1'b1);
      @(negedge clk);
      k++;
    end
    drive(u, 0, 1'b0);
    total++;
    if (k != n) begin
      bad++;
      $display("FAIL load_len u%0d: got %0d cycles, want %0d",
               u, k, n);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL load_seq u%0d: %0d bad cycles, first k=%0d addr=%0d want addr=%0d",
               u, errs, fk, fa, fk);
    end
    total++;
    if (o_rd(u) !== 1'b0) begin
      bad++;
      $display("FAIL load_rd_low u%0d: got %b want 0", u, o_rd(u));
    end
    for (int i = 0; i < n; i++) mimg[u][i] = rom[u][i];
  endtask

  task automatic do_write(bit u, bit noise);
    int n, errs, fi, fa, fd;
    n = mw[u] * mh[u];
    errs = 0; fi = -1; fa = -1; fd = -1;
    drive(u, 0, 1'b1);
    @(negedge clk);
    drive(u, 0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (o_wv(u) !== 1'b1 || o_wa(u) != i ||
          o_wd(u) != mimg[u][i] || o_busy(u) !== 1'b1 ||
          o_done(u) !== 1'b0) begin
        if (errs == 0) begin fi = i; fa = o_wa(u); fd = o_wd(u); end
        errs++;
      end
      cap[u][i] = o_wd(u);
      if (noise) drive(u, int'($urandom_range(0, 15)), 1'b1);
      @(negedge clk);
    end
    drive(u, 0, 1'b0);
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL write_burst u%0d: %0d bad, first i=%0d addr=%0d data=%0d want data=%0d",
               u, errs, fi, fa, fd, mimg[u][fi]);
    end
    total++;
    if (o_wv(u) !== 1'b0 || o_busy(u) !== 1'b0 || o_done(u) !== 1'b1) begin
      bad++;
      $display("FAIL write_end u%0d: valid=%b busy=%b done=%b want 0 0 1",
               u, o_wv(u), o_busy(u), o_done(u));
    end
    @(negedge clk);
    total++;
    if (o_done(u) !== 1'b0 || o_busy(u) !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse u%0d: done=%b busy=%b want 0 0",
               u, o_done(u), o_busy(u));
    end
  endtask

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset0 = 1'b1; reset1 = 1'b1;
    drive(0, 0, 1'b0); drive(1, 0, 1'b0);
    for (int i = 0; i < 128; i++) begin
      rom[0][i] = i % 64;
      rom[1][i] = int'($urandom_range(0, 4095));
    end
    model_reset(0); model_reset(1);
    @(negedge clk);
    chk("rst_busy", int'(busy0), 1);
    chk("rst_rd", int'(rd0), 1);
    chk("rst_valid", int'(wv0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_addr", int'(ra0), 0);
    reset0 = 1'b0;
    wait_load(0, 1'b0, 1'b1);
  endtask

  task automatic test_write_seq();
    do_write(0, 1'b0);
    chk("seq_last", cap[0][63], 63);
  endtask

  task automatic test_cw();
    issue(0, 9);
    do_write(0, 1'b0);
    chk("cw_27", cap[0][27], 35);
    chk("cw_28", cap[0][28], 27);
    chk("cw_35", cap[0][35], 36);
    chk("cw_36", cap[0][36], 28);
  endtask

  task automatic test_saturate();
    int o3, o4;
    o3 = mimg[0][3]; o4 = mimg[0][4];
    repeat (5) issue(0, 1);
    issue(0, 11);
    do_write(0, 1'b0);
    chk("sat_up_a", cap[0][3], o4);
    chk("sat_up_b", cap[0][4], o3);
    repeat (5) issue(0, 3);
    repeat (9) issue(0, 4);
    repeat (9) issue(0, 2);
    issue(0, 10);
    do_write(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmds(0, 60);
    do_write(0, 1'b1);
    run_cmds(0, 40);
    do_write(0, 1'b0);
  endtask

  task automatic test_reset_midwrite();
    drive(0, 0, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0);
    repeat (10) @(negedge clk);
    reset0 = 1'b1;
    #1;
    chk("mid_valid", int'(wv0), 0);
    chk("mid_busy", int'(busy0), 1);
    chk("mid_rd", int'(rd0), 1);
    chk("mid_addr", int'(ra0), 0);
    model_reset(0);
    for (int i = 0; i < 64; i++)
      rom[0][i] = int'($urandom_range(0, 255));
    @(negedge clk);
    reset0 = 1'b0;
    wait_load(0, 1'b0, 1'b1);
    do_write(0, 1'b0);
  endtask

  task automatic test_reload_avg();
    int ia;
    issue(0, 4);
    issue(0, 2);
    ia = 4 * 8 + 4;
    rom[0][ia] = 255; rom[0][ia + 1] = 255;
    rom[0][ia + 8] = 255; rom[0][ia + 9] = 254;
    drive(0, 12, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0);
    wait_load(0, 1'b1, 1'b0);
    issue(0, 7);
    do_write(0, 1'b0);
    chk("avg8_a", cap[0][ia], 254);
    chk("avg8_b", cap[0][ia + 1], 254);
    chk("avg8_c", cap[0][ia + 8], 254);
    chk("avg8_d", cap[0][ia + 9], 254);
  endtask

  task automatic test_wrap();
    int o96, o97;
    reset1 = 1'b0;
    wait_load(1, 1'b0, 1'b1);
    repeat (3) issue(1, 1);
    issue(1, 1);
    repeat (7) issue(1, 4);
    issue(1, 4);
    o96 = mimg[1][96]; o97 = mimg[1][97];
    issue(1, 11);
    do_write(1, 1'b0);
    chk("wrap_a", cap[1][96], o97);
    chk("wrap_b", cap[1][97], o96);
  endtask

  task automatic test_avg12();
    rom[1][96] = 4095; rom[1][97] = 4095;
    rom[1][112] = 4095; rom[1][113] = 4095;
    drive(1, 12, 1'b1);
    @(negedge clk);
    drive(1, 0, 1'b0);
    wait_load(1, 1'b0, 1'b0);
    issue(1, 7);
    do_write(1, 1'b0);
    chk("avg12_a", cap[1][96], 4095);
    chk("avg12_d", cap[1][113], 4095);
  endtask

  task automatic test_double_write();
    int first [128];
    int diffs;
    run_cmds(1, 30);
    issue(1, 5);
    do_write(1, 1'b1);
    first = cap[1];
    do_write(1, 1'b0);
    diffs = 0;
    for (int i = 0; i < 128; i++)
      if (cap[1][i] != first[i]) diffs++;
    chk("double_same", diffs, 0);
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_cw();
    test_saturate();
    test_back_to_back();
    test_reset_midwrite();
    test_reload_avg();
    test_wrap();
    test_avg12();
    test_double_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
